// File: rtl/switch_confirm_ctrl.sv
// rtl/switch_confirm_ctrl.sv - debounced confirm button, sticky clear-on-read flag and switch capture
// Optional feature macro: SWITCH_SNAPSHOT_EN (switchOut held from a per-press snapshot register).
module switch_confirm_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btnRaw,
    input  logic [15:0] switchRaw,
    input  logic        ioRead,
    input  logic        switchCtrl,
    input  logic [31:0] address,
    output logic        confirmation,
    output logic        confirmPulse,
    output logic [15:0] switchOut,
    output logic [7:0]  pressCount,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESS_DB,
        S_HELD,
        S_REL_DB
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             btn_meta;
    logic             btn_s;
    logic [15:0]      sw_meta;
    logic [15:0]      sw_s;
    logic             accept;
    logic             rd_clear;

    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_s    <= 1'b0;
            sw_meta  <= 16'h0000;
            sw_s     <= 16'h0000;
        end else begin
            btn_meta <= btnRaw;
            btn_s    <= btn_meta;
            sw_meta  <= switchRaw;
            sw_s     <= sw_meta;
        end
    end

    assign accept   = (state == S_PRESS_DB) && btn_s && (cnt == CNT_LAST);
    assign rd_clear = ioRead && switchCtrl && (address == 32'hffff_ff00);

`ifdef SWITCH_SNAPSHOT_EN
    logic [15:0] snapshot;

    always_ff @(posedge clk) begin
        if (rst) begin
            snapshot <= 16'h0000;
        end else if (accept) begin
            snapshot <= sw_s;
        end
    end

    assign switchOut = snapshot;
`else
    assign switchOut = sw_s;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            cnt          <= '0;
            busy         <= 1'b0;
            confirmation <= 1'b0;
            confirmPulse <= 1'b0;
            pressCount   <= 8'h00;
        end else begin
            confirmPulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (btn_s) begin
                        state <= S_PRESS_DB;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                S_PRESS_DB: begin
                    if (!btn_s) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_HELD;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                S_HELD: begin
                    if (!btn_s) begin
                        state <= S_REL_DB;
                        cnt   <= '0;
                    end
                end
                default: begin
                    // A bounce back to 1 during release returns to HELD, so one press yields one event
                    if (btn_s) begin
                        state <= S_HELD;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state <= S_IDLE;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
            endcase

            // Set has priority over clear-on-read so a press landing on the read edge is not lost
            if (accept) begin
                confirmPulse <= 1'b1;
                confirmation <= 1'b1;
                pressCount   <= pressCount + 8'h01;
            end else if (rd_clear) begin
                confirmation <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_switch_confirm_ctrl.sv
// tb/tb_switch_confirm_ctrl.sv - randomized and directed bench against a run-length reference model
module tb_switch_confirm_ctrl;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        btnRaw;
    logic [15:0] switchRaw;
    logic        ioRead;
    logic        switchCtrl;
    logic [31:0] address;
    logic        confirmation;
    logic        confirmPulse;
    logic [15:0] switchOut;
    logic [7:0]  pressCount;
    logic        busy;

    switch_confirm_ctrl #(.DEBOUNCE_CYCLES(N), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .btnRaw(btnRaw), .switchRaw(switchRaw),
        .ioRead(ioRead), .switchCtrl(switchCtrl), .address(address),
        .confirmation(confirmation), .confirmPulse(confirmPulse),
        .switchOut(switchOut), .pressCount(pressCount), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference: btn/switch seen two edges late; a press is a run of N+1 high samples
    // while released, a release is a run of N+1 low samples while held.
    bit        m_b1, m_b2;
    bit [15:0] m_s1, m_s2;
    bit        m_held;
    int        m_run;
    bit        m_conf, m_pulse, m_clear;
    bit [7:0]  m_count;
    bit [15:0] m_snap;
    int        pulses_seen;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        bit        bs;
        bit [15:0] sws;
        if (rst) begin
            m_b1 = 0; m_b2 = 0; m_s1 = 0; m_s2 = 0;
            m_held = 0; m_run = 0; m_conf = 0; m_pulse = 0; m_clear = 0;
            m_count = 0; m_snap = 0;
            return;
        end
        bs = m_b2;
        sws = m_s2;
        m_pulse = 0;
        if (!m_held) begin
            if (bs) begin
                m_run++;
                if (m_run == N + 1) begin
                    m_pulse = 1; m_held = 1; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end else begin
            if (!bs) begin
                m_run++;
                if (m_run == N + 1) begin
                    m_held = 0; m_run = 0;
                end
            end else begin
                m_run = 0;
            end
        end
        m_clear = ioRead && switchCtrl && (address == 32'hffff_ff00);
        if (m_pulse) begin
            m_conf = 1;
            m_count = m_count + 8'd1;
            m_snap = sws;
        end else if (m_clear) begin
            m_conf = 0;
        end
        m_b2 = m_b1; m_b1 = btnRaw;
        m_s2 = m_s1; m_s1 = switchRaw;
    endtask

    task automatic step();
        bit [15:0] exp_sw;
        @(posedge clk);
        model_edge();
        #1;
`ifdef SWITCH_SNAPSHOT_EN
        exp_sw = m_snap;
`else
        exp_sw = m_s2;
`endif
        check("confirmPulse", confirmPulse, m_pulse);
        check("confirmation", confirmation, m_conf);
        check("pressCount", pressCount, m_count);
        check("switchOut", switchOut, exp_sw);
        check("busy", busy, m_held || (m_run > 0));
        if (confirmPulse) pulses_seen++;
        if (m_pulse && m_clear) begin
            check("collide_conf", confirmation, 1);
        end
    endtask

    task automatic idle_bus();
        ioRead = 0; switchCtrl = 0; address = 32'h0;
    endtask

    task automatic do_reset();
        rst = 1; btnRaw = 0;
        step(); step();
        rst = 0;
    endtask

    task automatic press(input int hi, input int lo);
        btnRaw = 1;
        repeat (hi) step();
        btnRaw = 0;
        repeat (lo) step();
    endtask

    initial begin
        rst = 1; btnRaw = 1; switchRaw = 16'h1234; idle_bus();

        // Reset held two edges with button pressed; press accepted on edge 7 after release
        step(); step();
        check("rst_conf", confirmation, 0);
        check("rst_sw", switchOut, 0);
        check("rst_count", pressCount, 0);
        check("rst_busy", busy, 0);
        rst = 0;
        for (int e = 1; e <= 8; e++) begin
            step();
            if (e == 6 || e == 8) check("lat_pulse_low", confirmPulse, 0);
            if (e == 7) check("lat_pulse_high", confirmPulse, 1);
        end
        btnRaw = 0;
        repeat (8) step();

        // Clean press with a known switch pattern
        do_reset();
        switchRaw = 16'hA5C3;
        pulses_seen = 0;
        press(12, 8);
        check("clean_pulses", pulses_seen, 1);
        check("clean_count", pressCount, 1);
        check("clean_conf", confirmation, 1);
        check("clean_sw", switchOut, 16'hA5C3);

        // Glitch rejection
        do_reset();
        pulses_seen = 0;
        press(3, 8);
        check("glitch_pulses", pulses_seen, 0);
        check("glitch_conf", confirmation, 0);
        check("glitch_busy", busy, 0);

        // Release bounce
        do_reset();
        pulses_seen = 0;
        btnRaw = 1;
        repeat (10) step();
        for (int i = 0; i < 6; i++) begin
            btnRaw = i[0];
            step();
        end
        btnRaw = 0;
        repeat (10) step();
        check("bounce_count", pressCount, 1);
        check("bounce_pulses", pulses_seen, 1);

        // Clear-on-read: wrong address first, then the flag address
        ioRead = 1; switchCtrl = 1; address = 32'hffff_fff1;
        step();
        check("rd_other_addr", confirmation, 1);
        address = 32'hffff_ff00;
        step();
        check("rd_clear", confirmation, 0);
        idle_bus();
        step();

        // Count wrap with the read strobe held across the accepting edge
        do_reset();
        for (int i = 0; i < 255; i++) begin
            switchRaw = 16'($urandom);
            press(7, 8);
        end
        check("count_ff", pressCount, 8'hFF);
        ioRead = 1; switchCtrl = 1; address = 32'hffff_ff00;
        btnRaw = 1;
        repeat (7) step();
        check("wrap_conf", confirmation, 1);
        check("wrap_count", pressCount, 8'h00);
        idle_bus();
        btnRaw = 0;
        repeat (8) step();

        // Randomized traffic
        for (int k = 0; k < 300; k++) begin
            int len;
            btnRaw = 1'($urandom_range(0, 1));
            switchRaw = 16'($urandom);
            len = $urandom_range(1, 9);
            for (int j = 0; j < len; j++) begin
                rst = ($urandom_range(0, 199) == 0);
                ioRead = 1'($urandom_range(0, 1));
                switchCtrl = 1'($urandom_range(0, 1));
                case ($urandom_range(0, 2))
                    0: address = 32'hffff_ff00;
                    1: address = 32'hffff_fff1;
                    default: address = $urandom;
                endcase
                step();
            end
        end
        rst = 0;
        idle_bus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
